// File: rtl/signed_pow2_divide_sequencer.sv
// Sequential signed divide-by-2^s: one arithmetic right shift per clock, valid/ready on both sides.
// Define SIGNED_POW2_DIV_ROUND_TO_ZERO_EN for round-toward-zero; otherwise the result rounds toward -inf.
module signed_pow2_divide_sequencer #(
    parameter int N  = 8,
    parameter int SW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          up_valid,
    output logic          up_ready,
    input  logic [N-1:0]  up_data,
    input  logic [SW-1:0] up_shift,
    output logic          down_valid,
    input  logic          down_ready,
    output logic [N-1:0]  down_data,
    output logic          busy
);

`ifdef SIGNED_POW2_DIV_ROUND_TO_ZERO_EN
    typedef enum logic [1:0] {IDLE, SHIFT, ADJUST, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

    localparam logic [SW-1:0] SMAX = SW'(N - 1);

    state_t               state, state_nx;
    logic signed [N-1:0]  acc;
    logic [SW-1:0]        cnt;
    logic [SW-1:0]        shift_sat;
    logic                 last_shift;
`ifdef SIGNED_POW2_DIV_ROUND_TO_ZERO_EN
    logic                 sticky;
`endif

    function automatic logic signed [N-1:0] asr1(input logic signed [N-1:0] x);
        return {x[N-1], x[N-1:1]};
    endfunction

`ifdef SIGNED_POW2_DIV_ROUND_TO_ZERO_EN
    // Floor result is <= 0 whenever the increment applies, so it cannot overflow.
    function automatic logic signed [N-1:0] round_to_zero(input logic signed [N-1:0] x,
                                                          input logic st);
        return (x[N-1] && st) ? x + {{(N-1){1'b0}}, 1'b1} : x;
    endfunction
`endif

    assign shift_sat  = (up_shift > SMAX) ? SMAX : up_shift;
    assign last_shift = (cnt <= SW'(1));
    assign down_data  = acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Without rounding, s = 0 still spends one idle SHIFT cycle so latency is never zero.
    always_comb begin
        state_nx   = state;
        up_ready   = 1'b0;
        busy       = 1'b1;
        down_valid = 1'b0;
        case (state)
            IDLE: begin
                up_ready = 1'b1;
                busy     = 1'b0;
                if (up_valid) begin
`ifdef SIGNED_POW2_DIV_ROUND_TO_ZERO_EN
                    state_nx = (shift_sat != '0) ? SHIFT : ADJUST;
`else
                    state_nx = SHIFT;
`endif
                end
            end
            SHIFT: begin
                if (last_shift) begin
`ifdef SIGNED_POW2_DIV_ROUND_TO_ZERO_EN
                    state_nx = ADJUST;
`else
                    state_nx = DONE;
`endif
                end
            end
`ifdef SIGNED_POW2_DIV_ROUND_TO_ZERO_EN
            ADJUST: begin
                state_nx = DONE;
            end
`endif
            DONE: begin
                down_valid = 1'b1;
                if (down_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            cnt    <= '0;
`ifdef SIGNED_POW2_DIV_ROUND_TO_ZERO_EN
            sticky <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (up_valid) begin
                        acc    <= up_data;
                        cnt    <= shift_sat;
`ifdef SIGNED_POW2_DIV_ROUND_TO_ZERO_EN
                        sticky <= 1'b0;
`endif
                    end
                end
                SHIFT: begin
                    if (cnt != '0) begin
                        acc    <= asr1(acc);
                        cnt    <= cnt - SW'(1);
`ifdef SIGNED_POW2_DIV_ROUND_TO_ZERO_EN
                        sticky <= sticky | acc[0];
`endif
                    end
                end
`ifdef SIGNED_POW2_DIV_ROUND_TO_ZERO_EN
                ADJUST: begin
                    acc <= round_to_zero(acc, sticky);
                end
`endif
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_signed_pow2_divide_sequencer.sv
// Directed and random checks of signed_pow2_divide_sequencer against an arithmetic division model.
module tb_signed_pow2_divide_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       up_valid;
    logic       up_ready;
    logic [7:0] up_data;
    logic [2:0] up_shift;
    logic       down_valid;
    logic       down_ready;
    logic [7:0] down_data;
    logic       busy;

    int checks = 0;
    int errors = 0;

    signed_pow2_divide_sequencer #(.N(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .up_valid   (up_valid),
        .up_ready   (up_ready),
        .up_data    (up_data),
        .up_shift   (up_shift),
        .down_valid (down_valid),
        .down_ready (down_ready),
        .down_data  (down_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Quotient of a / 2^s: truncating with rounding enabled, floor otherwise.
    function automatic int model_q(input int a, input int s);
        int d;
        int q;
        d = 1 << s;
        q = a / d;
`ifndef SIGNED_POW2_DIV_ROUND_TO_ZERO_EN
        if (a < 0 && (a % d) != 0) q = q - 1;
`endif
        return q;
    endfunction

    function automatic int model_lat(input int s);
`ifdef SIGNED_POW2_DIV_ROUND_TO_ZERO_EN
        return s + 1;
`else
        return (s == 0) ? 1 : s;
`endif
    endfunction

    task automatic run_op(input string tag, input logic [7:0] a, input int s,
                          input int bp, input bit hold_valid);
        int         lat;
        int         q;
        logic [7:0] expd;
        logic [7:0] held;
        q    = model_q(int'($signed(a)), s);
        expd = 8'(q);
        @(negedge clk);
        chk({tag, "_up_ready_idle"}, 32'(up_ready), 32'd1);
        up_valid   = 1'b1;
        up_data    = a;
        up_shift   = 3'(s);
        down_ready = 1'b0;
        @(posedge clk);
        #1;
        up_valid = hold_valid;
        up_data  = 8'($urandom_range(0, 255));
        up_shift = 3'($urandom_range(0, 7));
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (down_valid) break;
        end
        chk({tag, "_valid"}, 32'(down_valid), 32'd1);
        chk({tag, "_latency"}, 32'(lat), 32'(model_lat(s)));
        chk({tag, "_data"}, 32'(down_data), 32'(expd));
        held = down_data;
        for (int i = 0; i < bp; i++) begin
            @(posedge clk);
            #1;
            chk({tag, "_bp_valid"}, 32'(down_valid), 32'd1);
            chk({tag, "_bp_data"}, 32'(down_data), 32'(held));
            chk({tag, "_bp_up_ready"}, 32'(up_ready), 32'd0);
        end
        down_ready = 1'b1;
        @(posedge clk);
        #1;
        up_valid   = 1'b0;
        down_ready = 1'b0;
        chk({tag, "_post_valid"}, 32'(down_valid), 32'd0);
        chk({tag, "_post_ready"}, 32'(up_ready), 32'd1);
        chk({tag, "_post_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        bit seen;
        rst_n      = 1'b0;
        up_valid   = 1'b0;
        up_data    = 8'h00;
        up_shift   = 3'd0;
        down_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_up_ready", 32'(up_ready), 32'd1);
        chk("rst_down_valid", 32'(down_valid), 32'd0);
        chk("rst_down_data", 32'(down_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;

        run_op("d100s3", 8'h64, 3, 0, 1'b0);
        run_op("m7s1", 8'hF9, 1, 0, 1'b0);
        run_op("m1s7", 8'hFF, 7, 0, 1'b0);
        run_op("m128s7", 8'h80, 7, 0, 1'b0);
        run_op("m5s0", 8'hFB, 0, 0, 1'b1);
        run_op("hold", 8'h9D, 4, 0, 1'b1);
        run_op("bp10", 8'hA3, 2, 10, 1'b0);

        // Reset during the second SHIFT cycle of s = 5.
        @(negedge clk);
        up_valid = 1'b1;
        up_data  = 8'h5A;
        up_shift = 3'd5;
        @(posedge clk);
        #1;
        up_valid = 1'b0;
        @(posedge clk);
        #2;
        chk("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mrst_up_ready", 32'(up_ready), 32'd1);
        chk("mrst_down_valid", 32'(down_valid), 32'd0);
        chk("mrst_down_data", 32'(down_data), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (down_valid || busy) seen = 1'b1;
        end
        chk("mrst_no_result", 32'(seen), 32'd0);

        for (int i = 0; i < 200; i++) begin
            run_op("rand", 8'($urandom_range(0, 255)), $urandom_range(0, 7),
                   $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
